// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
// Types and helpers shared by the ROM port arbiter and its data-lane
// extractor. It holds the access-size encodings, the response owner and
// the response-register layout.
package rom_arb_pkg;

    // Access size encodings on d_size_i. 2'b11 is also treated as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // The response register holds everything needed to steer the ROM
    // word back to the right port one cycle after the grant.
    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [1:0] size;
        logic [1:0] off;
        logic       err;
    } resp_t;

    // Returns 1 when a data access is misaligned for its size.
    // Bytes are never misaligned.
    function automatic logic data_misaligned(input logic [1:0] size,
                                             input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/rom_lane_extract.sv
// rom_lane_extract
// Purely combinational selection of a byte, half-word or word from a
// 32-bit ROM word, zero-extended to 32 bits.
// Ports:
//   word_i  32-bit word returned by the ROM
//   size_i  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   off_i   byte offset within the word (addr[1:0])
//   data_o  extracted, zero-extended result
module rom_lane_extract (
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);
    import rom_arb_pkg::*;

    logic [7:0] lane [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        data_o = '0;
        case (size_i)
            SZ_BYTE: data_o = {24'h0, lane[off_i]};
            // Only offsets 0 and 2 reach here without an error; the
            // error path masks anything else downstream.
            SZ_HALF: data_o = off_i[1] ? {16'h0, word_i[31:16]}
                                       : {16'h0, word_i[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares a single-ported, synchronous-read ROM between the instruction
// fetch port and the load/store data port. One access is granted per
// cycle (combinational grant); the read word returns to the winner one
// cycle later. Data reads are byte/half extracted and zero-extended.
// Out-of-range and misaligned accesses are granted but do not enable the
// ROM; they come back with err=1 and rdata=0.
//
// Build option: define ROM_ARB_ROUND_ROBIN_EN to alternate the winner on
// conflicts. Otherwise data has fixed priority over fetch.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   f_req_i/f_addr_i/f_gnt_o         fetch request side
//   f_rvalid_o/f_rdata_o/f_err_o     fetch response side
//   d_req_i/d_addr_i/d_size_i/d_gnt_o data request side
//   d_rvalid_o/d_rdata_o/d_err_o     data response side
//   rom_en_o/rom_addr_o/rom_rdata_i  ROM macro interface
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter  int ROM_DEPTH = 1024,
    localparam int ROM_AW    = $clog2(ROM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              f_req_i,
    input  logic [31:0]       f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [31:0]       f_rdata_o,
    output logic              f_err_o,
    input  logic              d_req_i,
    input  logic [31:0]       d_addr_i,
    input  logic [1:0]        d_size_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_err_o,
    output logic              rom_en_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [31:0]       rom_rdata_i
);

    logic        conflict;
    logic        data_wins;
    logic        gnt_any;
    logic [31:0] sel_addr;
    logic        out_of_range;
    logic        misaligned;
    logic        acc_err;
    resp_t       resp_reg;
    resp_t       resp_next;
    logic [31:0] d_extract;

    assign conflict = f_req_i & d_req_i;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    // Remembers who won the last conflict; reset as "fetch" so the first
    // conflict after reset goes to data.
    owner_e last_win_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_win_reg <= OWN_FETCH;
        end else if (conflict) begin
            last_win_reg <= data_wins ? OWN_DATA : OWN_FETCH;
        end
    end

    assign data_wins = (last_win_reg == OWN_FETCH);
`else
    assign data_wins = 1'b1;
`endif

    // Grants are masked while reset is asserted so every output reads 0.
    assign d_gnt_o = rst_ni & d_req_i & (~f_req_i | data_wins);
    assign f_gnt_o = rst_ni & f_req_i & ~(conflict & data_wins);
    assign gnt_any = f_gnt_o | d_gnt_o;

    assign sel_addr     = d_gnt_o ? d_addr_i : f_addr_i;
    assign out_of_range = ({2'b00, sel_addr[31:2]} >= 32'(ROM_DEPTH));
    assign misaligned   = d_gnt_o ? data_misaligned(d_size_i, d_addr_i[1:0])
                                  : (f_addr_i[1:0] != 2'b00);
    assign acc_err      = out_of_range | misaligned;

    assign rom_en_o   = gnt_any & ~acc_err;
    assign rom_addr_o = gnt_any ? sel_addr[ROM_AW+1:2] : '0;

    always_comb begin
        resp_next       = '0;
        resp_next.valid = gnt_any;
        resp_next.owner = d_gnt_o ? OWN_DATA : OWN_FETCH;
        resp_next.size  = d_size_i;
        resp_next.off   = sel_addr[1:0];
        resp_next.err   = acc_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_reg <= '0;
        end else begin
            resp_reg <= resp_next;
        end
    end

    rom_lane_extract u_lane_extract (
        .word_i (rom_rdata_i),
        .size_i (resp_reg.size),
        .off_i  (resp_reg.off),
        .data_o (d_extract)
    );

    assign f_rvalid_o = resp_reg.valid & (resp_reg.owner == OWN_FETCH);
    assign d_rvalid_o = resp_reg.valid & (resp_reg.owner == OWN_DATA);
    assign f_err_o    = f_rvalid_o & resp_reg.err;
    assign d_err_o    = d_rvalid_o & resp_reg.err;
    assign f_rdata_o  = (f_rvalid_o & ~resp_reg.err) ? rom_rdata_i : 32'h0;
    assign d_rdata_o  = (d_rvalid_o & ~resp_reg.err) ? d_extract  : 32'h0;

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single-ported, synchronous-read boot/program ROM between the instruction-fetch port and the load/store data port. Grants at most one access per cycle and drives the ROM address and enable. Returns the read word one cycle later to the winning requester. For the data port, the returned word is byte-/half-extracted and zero-extended; misaligned and out-of-range accesses are flagged. Sits between the core's fetch/LSU request interfaces and the ROM macro.

## Interface
- ROM_DEPTH, 1024, ROM size in 32-bit words; must be a power of two ≥ 2.
- ROM_AW, $clog2(ROM_DEPTH), ROM word-address width; derived, never overridden.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- f_req_i  in  1  fetch request; held with f_addr_i until f_gnt_o.
- f_addr_i  in  32  fetch byte address; word access only.
- f_gnt_o  out  1  fetch granted this cycle (combinational).
- f_rvalid_o  out  1  fetch response valid (one-cycle pulse).
- f_rdata_o  out  32  fetch read word.
- f_err_o  out  1  fetch error, qualified by f_rvalid_o.
- d_req_i  in  1  data request; held with d_addr_i/d_size_i until d_gnt_o.
- d_addr_i  in  32  data byte address.
- d_size_i  in  2  00 byte, 01 half, 10/11 word.
- d_gnt_o  out  1  data granted this cycle (combinational).
- d_rvalid_o  out  1  data response valid (one-cycle pulse).
- d_rdata_o  out  32  extracted, zero-extended read data.
- d_err_o  out  1  data error, qualified by d_rvalid_o.
- rom_en_o  out  1  ROM read enable.
- rom_addr_o  out  ROM_AW  ROM word address (byte address >> 2).
- rom_rdata_i  in  32  ROM word; valid the cycle after rom_en_o.

## Operation
- Each cycle, at most one of f_gnt_o/d_gnt_o is asserted, only when the matching req is high; a requester with req high alone is always granted (no idle bubbles).
- Both requesting: winner chosen per Configuration; the loser keeps req high and is served in a later cycle.
- On grant of a valid access: rom_en_o=1, rom_addr_o=addr[ROM_AW+1:2]. A response register captures owner, size, addr[1:0], err, valid.
- Error conditions (the access is still granted; rom_en_o=0 for that grant):
  - addr[31:2] ≥ ROM_DEPTH.
  - Fetch: f_addr_i[1:0]≠0.
  - Data: half with addr[0]=1; word with addr[1:0]≠0.
- Response cycle: the owner's rvalid=1. On error, err=1 and rdata=0.
- Data extraction:
  - byte: rom_rdata_i[8*off+7:8*off] zero-extended.
  - half: off=0 → [15:0]; off=2 → [31:16].
  - word: full word.
- Fetch rdata = rom_rdata_i. The non-owner's rdata is 0.
- No back-pressure on responses: requesters must accept rvalid.

## Timing
- Grant: combinational, same cycle as req.
- Response latency: exactly 1 cycle after grant.
- Throughput: 1 access/cycle, back-to-back, any owner mix. A grant in cycle N+1 coexists with the response for cycle N.
- Reset values: all *_gnt_o, *_rvalid_o, *_err_o, rom_en_o = 0; *_rdata_o = 0; rom_addr_o = 0; response register cleared; round-robin pointer = "last winner fetch".
- Reset asserted mid-transaction: the in-flight response is dropped and no rvalid is produced after reset release.
- Simultaneous response for one port and new grant to the other port in the same cycle: legal.

## Configuration
- ROM_ARB_ROUND_ROBIN_EN defined: on conflict, the port that did not win the last conflict wins. The pointer updates only on conflict cycles. First conflict after reset goes to data.
- Undefined: fixed priority, data always beats fetch. Fetch can starve under continuous data requests (accepted; the LSU never issues back-to-back forever).

## Structure
- rom_arb_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), owner enum (OWN_FETCH, OWN_DATA), response-register struct.
- Sub-module rom_lane_extract: combinational size/offset extraction with zero-extension; instantiated once on the data return path.

## Test plan
- Fetch-only stream 0x0, 0x4, 0x8 → f_gnt_o same cycle; f_rdata_o = rom[0], rom[1], rom[2] on consecutive cycles, 1-cycle latency.
- Data byte reads at 0x11..0x13 with rom[4]=0xA1B2C3D4 → d_rdata_o 0xC3, 0xB2, 0xA1. Half at 0x12 → 0x0000A1B2.
- Both requesting for 4 cycles, RR enabled → grants alternate D, F, D, F. RR disabled → D for 4 cycles, f_gnt_o=0.
- d_addr_i=0x3 word; f_addr_i=ROM_DEPTH*4 → granted, rom_en_o=0, err=1 and rdata=0 next cycle.
- rst_ni dropped the cycle after a grant → no rvalid after release; all outputs 0 during reset.
